// File: rtl/freqgen_defs.sv
// Shared register map, CTRL bit positions and channel state encoding.
package freqgen_defs;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_HIGH = 2'd1;
  localparam logic [1:0] REG_LOW  = 2'd2;
  localparam logic [1:0] REG_BOTH = 2'd3;

  localparam int unsigned EN_BIT      = 8;
  localparam int unsigned ONESHOT_BIT = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } chan_state_e;

endpackage

// File: rtl/freqgen_chan.sv
// One output channel: control/shadow registers, tick select, phase FSM and registered output.
module freqgen_chan
  import freqgen_defs::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV_W = 5,
  parameter int unsigned PRE_W = 2 ** DIV_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [PRE_W-1:0] i_pre_cnt,
  input  logic             i_wr_ctrl,
  input  logic             i_wr_high,
  input  logic             i_wr_low,
  input  logic [15:0]      i_data,
  output logic [15:0]      o_ctrl,
  output logic [CNT_W-1:0] o_high,
  output logic [CNT_W-1:0] o_low,
  output logic             o_busy,
  output logic             o_out
);

  logic [DIV_W-1:0] r_div;
  logic             r_en;
  logic             r_oneshot;
  logic [CNT_W-1:0] r_sh_high;
  logic [CNT_W-1:0] r_sh_low;
  logic [CNT_W-1:0] r_act_high;
  logic [CNT_W-1:0] r_act_low;
  logic [CNT_W-1:0] r_cnt;
  chan_state_e      r_state;
  logic             r_out;

  chan_state_e      w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_act_high_nxt;
  logic [CNT_W-1:0] w_act_low_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_en_clr;
  logic [PRE_W-1:0] w_mask;
  logic             w_tick;
  logic             w_unused_data;

  // Tick when the low div bits of the prescaler are all ones (always when div is 0).
  assign w_mask        = ~({PRE_W{1'b1}} << r_div);
  assign w_tick        = ((i_pre_cnt & w_mask) == w_mask);
  assign w_cnt_inc     = r_cnt + CNT_W'(1);
  assign w_unused_data = ^i_data;

  // Control and shadow registers; a CTRL write overrides the one-shot self-clear of en.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div     <= '0;
      r_en      <= 1'b0;
      r_oneshot <= 1'b0;
      r_sh_high <= '0;
      r_sh_low  <= '0;
    end else begin
      if (i_wr_ctrl) begin
        r_div     <= i_data[DIV_W-1:0];
        r_en      <= i_data[EN_BIT];
        r_oneshot <= i_data[ONESHOT_BIT];
      end else if (w_en_clr) begin
        r_en <= 1'b0;
      end
      if (i_wr_high) r_sh_high <= i_data[CNT_W-1:0];
      if (i_wr_low)  r_sh_low  <= i_data[CNT_W-1:0];
    end
  end

  // Phase FSM next state; boundaries reload from the pre-write shadows.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_act_high_nxt = r_act_high;
    w_act_low_nxt  = r_act_low;
    w_en_clr       = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        ST_IDLE: begin
          w_cnt_nxt = '0;
          if (r_en && (r_sh_high != '0)) begin
            w_act_high_nxt = r_sh_high;
            w_act_low_nxt  = r_sh_low;
            w_state_nxt    = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_cnt_inc == r_act_high) begin
            w_cnt_nxt = '0;
            if (r_act_low == '0) begin
              // Full duty: keep high, pick up new shadows at every high-phase end.
              w_act_high_nxt = r_sh_high;
              w_act_low_nxt  = r_sh_low;
              w_state_nxt    = (r_sh_high != '0) ? ST_HIGH : ST_IDLE;
            end else begin
              w_state_nxt = ST_LOW;
            end
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        ST_LOW: begin
          if (w_cnt_inc == r_act_low) begin
            w_cnt_nxt = '0;
            if (r_oneshot) begin
              w_en_clr    = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_act_high_nxt = r_sh_high;
              w_act_low_nxt  = r_sh_low;
              w_state_nxt    = (r_sh_high != '0) ? ST_HIGH : ST_IDLE;
            end
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
    // Disable acts immediately, independent of the tick.
    if (i_wr_ctrl && !i_data[EN_BIT]) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end
  end

  // FSM state, active counts and output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_act_high <= '0;
      r_act_low  <= '0;
      r_out      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_act_high <= w_act_high_nxt;
      r_act_low  <= w_act_low_nxt;
      r_out      <= (w_state_nxt == ST_HIGH);
    end
  end

  // CTRL readback image.
  always_comb begin
    o_ctrl              = '0;
    o_ctrl[DIV_W-1:0]   = r_div;
    o_ctrl[EN_BIT]      = r_en;
    o_ctrl[ONESHOT_BIT] = r_oneshot;
  end

  assign o_high = r_sh_high;
  assign o_low  = r_sh_low;
  assign o_busy = (r_state != ST_IDLE);
  assign o_out  = r_out;

endmodule

// File: rtl/freqgen_multi.sv
// Multi-channel frequency generator: shared prescaler, bus decode and registered readback.
module freqgen_multi
  import freqgen_defs::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned DIV_W    = 5
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [15:0]         i_addr,
  input  logic [15:0]         i_data,
  input  logic                i_we,
  output logic [15:0]         o_rdata,
  output logic [CHANNELS-1:0] o_out
);

  localparam int unsigned PRE_W = 2 ** DIV_W;
  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [PRE_W-1:0]    r_pre_cnt;
  logic                w_addr_ok;
  logic [CH_W-1:0]     w_ch;
  logic [1:0]          w_reg;
  logic [15:0]         w_rdata;
  logic [15:0]         w_ctrl [CHANNELS];
  logic [CNT_W-1:0]    w_high [CHANNELS];
  logic [CNT_W-1:0]    w_low  [CHANNELS];
  logic [CHANNELS-1:0] w_busy;

  assign w_addr_ok = (i_addr < 16'(CHANNELS * 4));
  assign w_ch      = i_addr[2 +: CH_W];
  assign w_reg     = i_addr[1:0];

  // Free-running prescaler shared by all channels.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_pre_cnt <= '0;
    else       r_pre_cnt <= r_pre_cnt + PRE_W'(1);
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic w_hit;
    assign w_hit = i_we && w_addr_ok && (w_ch == CH_W'(g));

    freqgen_chan #(
      .CNT_W (CNT_W),
      .DIV_W (DIV_W),
      .PRE_W (PRE_W)
    ) u_chan (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_pre_cnt (r_pre_cnt),
      .i_wr_ctrl (w_hit && (w_reg == REG_CTRL)),
      .i_wr_high (w_hit && ((w_reg == REG_HIGH) || (w_reg == REG_BOTH))),
      .i_wr_low  (w_hit && ((w_reg == REG_LOW) || (w_reg == REG_BOTH))),
      .i_data    (i_data),
      .o_ctrl    (w_ctrl[g]),
      .o_high    (w_high[g]),
      .o_low     (w_low[g]),
      .o_busy    (w_busy[g]),
      .o_out     (o_out[g])
    );
  end

  // Read mux; unmapped addresses return 0.
  always_comb begin
    w_rdata = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (w_addr_ok && (w_ch == CH_W'(n))) begin
        case (w_reg)
          REG_CTRL: w_rdata = w_ctrl[n];
          REG_HIGH: w_rdata = 16'(w_high[n]);
          REG_LOW:  w_rdata = 16'(w_low[n]);
          default:  w_rdata = {14'b0, w_busy[n], o_out[n]};
        endcase
      end
    end
  end

  // Registered read data, valid one cycle after the address.
  always_ff @(posedge i_clk) begin
    if (i_rst) o_rdata <= '0;
    else       o_rdata <= w_rdata;
  end

endmodule

// File: tb/tb_freqgen_multi.sv
// Directed + randomized bench for freqgen_multi against a phase-countdown reference model.
module tb_freqgen_multi;

  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   addr;
  logic [15:0]   data;
  logic          we;
  logic [15:0]   rdata;
  logic [CH-1:0] out;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  freqgen_multi #(
    .CHANNELS (CH),
    .CNT_W    (16),
    .DIV_W    (5)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_addr  (addr),
    .i_data  (data),
    .i_we    (we),
    .o_rdata (rdata),
    .o_out   (out)
  );

  // Reference model: each running channel holds a level and the ticks left in that level.
  longint unsigned m_pre;
  bit m_en [CH], m_one [CH], m_run [CH], m_lvl [CH];
  int m_div [CH], m_sh_hi [CH], m_sh_lo [CH], m_a_hi [CH], m_a_lo [CH], m_left [CH];
  logic [15:0]   exp_rdata;
  logic [CH-1:0] exp_out;

  function automatic logic [15:0] model_read(input logic [15:0] a);
    int c;
    int r;
    c = int'(a) / 4;
    r = int'(a) % 4;
    if (int'(a) >= CH * 4) return 16'h0;
    case (r)
      0:       return 16'((m_one[c] << 9) | (m_en[c] << 8) | m_div[c]);
      1:       return 16'(m_sh_hi[c]);
      2:       return 16'(m_sh_lo[c]);
      default: return {14'b0, m_run[c], m_run[c] & m_lvl[c]};
    endcase
  endfunction

  task automatic load_period(input int c);
    m_a_hi[c] = m_sh_hi[c];
    m_a_lo[c] = m_sh_lo[c];
    if (m_a_hi[c] == 0) m_run[c] = 0;
    else begin
      m_lvl[c]  = 1;
      m_left[c] = m_a_hi[c];
    end
  endtask

  task automatic model_edge();
    longint unsigned per;
    int c;
    if (rst) begin
      m_pre = 0;
      for (int i = 0; i < CH; i++) begin
        m_en[i] = 0; m_one[i] = 0; m_run[i] = 0; m_lvl[i] = 0; m_div[i] = 0;
        m_sh_hi[i] = 0; m_sh_lo[i] = 0; m_a_hi[i] = 0; m_a_lo[i] = 0; m_left[i] = 0;
      end
      exp_rdata = 16'h0;
    end else begin
      exp_rdata = model_read(addr);
      for (int i = 0; i < CH; i++) begin
        per = 64'd1 << m_div[i];
        if ((m_pre % per) == per - 1) begin
          if (!m_run[i]) begin
            if (m_en[i] && m_sh_hi[i] != 0) begin
              m_run[i] = 1;
              load_period(i);
            end
          end else begin
            m_left[i]--;
            if (m_left[i] == 0) begin
              if (m_lvl[i] && m_a_lo[i] == 0) load_period(i);
              else if (m_lvl[i]) begin
                m_lvl[i]  = 0;
                m_left[i] = m_a_lo[i];
              end else if (m_one[i]) begin
                m_en[i]  = 0;
                m_run[i] = 0;
              end else load_period(i);
            end
          end
        end
      end
      m_pre++;
      if (we && int'(addr) < CH * 4) begin
        c = int'(addr) / 4;
        case (addr[1:0])
          2'd0: begin
            m_div[c] = int'(data[4:0]);
            m_en[c]  = data[8];
            m_one[c] = data[9];
            if (!data[8]) m_run[c] = 0;
          end
          2'd1: m_sh_hi[c] = int'(data);
          2'd2: m_sh_lo[c] = int'(data);
          default: begin
            m_sh_hi[c] = int'(data);
            m_sh_lo[c] = int'(data);
          end
        endcase
      end
    end
    for (int i = 0; i < CH; i++) exp_out[i] = m_run[i] & m_lvl[i];
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    vectors++;
    assert (out === exp_out) else begin
      miscompares++;
      $error("FAIL out: got %b exp %b at %0t", out, exp_out, $time);
    end
    vectors++;
    assert (rdata === exp_rdata) else begin
      miscompares++;
      $error("FAIL rdata: got %h exp %h at %0t", rdata, exp_rdata, $time);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr = a;
    data = d;
    we   = 1'b1;
    step();
    we   = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    addr = a;
    we   = 1'b0;
    step();
  endtask

  // Advance until the model has channel c at the given output level, bounded.
  task automatic wait_lvl(input int c, input bit lvl, input int budget);
    int k;
    k = 0;
    while (((m_run[c] & m_lvl[c]) != lvl) && k < budget) begin
      step();
      k++;
    end
    vectors++;
    assert (k < budget) else begin
      miscompares++;
      $error("FAIL wait ch%0d: got timeout after %0d exp level %0d", c, k, lvl);
    end
  endtask

  initial begin
    rst  = 1'b1;
    we   = 1'b0;
    addr = 16'h0;
    data = 16'h0;
    step();
    step();
    rst = 1'b0;
    rd(16'h0);
    rd(16'h3);

    // Basic 3/2 waveform on ch0.
    wr(16'h1, 16'd3);
    wr(16'h2, 16'd2);
    wr(16'h0, 16'h0100);
    repeat (20) step();

    // ch1: div=2, both counts 1.
    wr(16'h7, 16'd1);
    wr(16'h4, 16'h0102);
    repeat (24) step();

    // ch2 one-shot pulse, then readback of STATUS and CTRL.
    wr(16'h9, 16'd4);
    wr(16'hA, 16'd4);
    wr(16'h8, 16'h0300);
    repeat (16) step();
    rd(16'hB);
    rd(16'h8);
    repeat (6) step();

    // Shadow update in the middle of a ch0 high phase.
    wait_lvl(0, 1'b0, 20);
    wait_lvl(0, 1'b1, 20);
    step();
    wr(16'h1, 16'd6);
    repeat (25) step();

    // Full duty on ch3, HIGH=0 on ch2, disable ch0 while high.
    wr(16'hD, 16'd5);
    wr(16'hE, 16'd0);
    wr(16'hC, 16'h0100);
    repeat (15) step();
    wr(16'h9, 16'd0);
    wr(16'h8, 16'h0100);
    repeat (10) step();
    wait_lvl(0, 1'b1, 30);
    wr(16'h0, 16'h0000);
    step();

    // Readback and out-of-range access.
    rd(16'h0);
    rd(16'h1);
    rd(16'hF);
    wr(16'd16, 16'h0101);
    rd(16'd16);
    rd(16'd19);

    // Reset mid-period, then every register must read 0.
    wr(16'h0, 16'h0100);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int a = 0; a < CH * 4; a++) rd(16'(a));

    // Randomized bus traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        int a;
        logic [15:0] d;
        a = $urandom_range(0, CH * 4 + 3);
        if (a % 4 == 0) d = 16'($urandom) & 16'hFFE3;
        else            d = 16'($urandom_range(0, 5));
        if (a % 4 == 0 && $urandom_range(0, 3) != 0) d[8] = 1'b1;
        wr(16'(a), d);
      end else begin
        rd(16'($urandom_range(0, CH * 4 + 7)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/freqgen_multi.md
Name: freqgen_multi

Overview:
Parametrised multi-channel successor of the single-channel frequency generator. It provides CHANNELS independent square/PWM outputs on one clock domain, with no derived or ripple clocks: a shared free-running prescaler produces per-channel clock-enable ticks. Each channel adds double-buffered high/low counts with glitch-free update at period boundaries, a one-shot mode and register readback. It sits on the CPU peripheral bus next to the other memory-mapped peripherals.

Parameters:
CHANNELS, 4, number of independent outputs (1..8)
CNT_W, 16, width of high/low phase counts (at most 16)
DIV_W, 5, width of prescaler select; prescaler counter is 2**DIV_W bits wide

Ports:
clk  input  1  system clock; the bus is sampled on this clock too
rst  input  1  synchronous, active-high reset
addr  input  16  register address
data  input  16  write data
we  input  1  write strobe, one write per cycle it is high
rdata  output  16  read data, registered
out  output  CHANNELS  generated outputs, bit n = channel n

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). On reset, all registers, prescaler, FSMs, out and rdata are 0.
- Address decode: channel = addr[2 +: clog2(CHANNELS)], reg = addr[1:0]. Addresses >= CHANNELS*4 are ignored on write and read 0.
- Reg 0 CTRL: bits[DIV_W-1:0] div, bit 8 en, bit 9 oneshot.
- Reg 1 HIGH: writes shadow high count.
- Reg 2 LOW: writes shadow low count.
- Reg 3 write: writes both shadow high and shadow low with data. Reg 3 read: STATUS = {14'b0, busy, out_n}, where busy = (state != IDLE).
- Readback: rdata <= selected register on every clk edge, so data is valid one cycle after addr. HIGH and LOW read back the shadow values.
- Prescaler: pre_cnt increments every clk. Channel tick = AND of pre_cnt[div-1:0], or 1 when div=0, so a tick occurs every 2**div clk cycles.
- Per-channel FSM (all updates on tick only, except disable):
  - IDLE: out=0, cnt=0. On tick with en=1 and shadow_high != 0: load act_high/act_low from shadow, enter HIGH.
  - HIGH: out=1. On tick, if cnt+1 == act_high then cnt<=0 and:
    - act_low == 0: reload shadows and stay HIGH (100% duty). If the new high is 0, go to IDLE.
    - otherwise: go to LOW.
    Else cnt<=cnt+1.
  - LOW: out=0. On tick, if cnt+1 == act_low then cnt<=0 and:
    - oneshot=1: clear en, go to IDLE.
    - otherwise: reload shadows; go to HIGH if the new high != 0, else IDLE.
    Else cnt<=cnt+1.
- out is a registered copy of state==HIGH; no combinational path from bus to out.
- Period = (act_high + act_low) * 2**div clk cycles. Duty = act_high / period.
- Disable: writing en=0 forces IDLE on the next clk regardless of tick. out is 0 one cycle after the write.
- Simultaneous write and period boundary: the boundary loads the pre-write shadow. The new value takes effect at the following boundary.
- A write to CTRL.div takes effect immediately for tick generation. The phase count is not reset.
- cnt compare is CNT_W bits wide. A shadow value of 0 is handled only as the special cases above, with no wrap-through.
- Reset mid-operation: all channels go to IDLE and out goes to 0 in the same cycle rst is sampled. Shadows clear to 0.

Decomposition:
- Shared defines/package freqgen_defs holds:
  - register offsets REG_CTRL=0, REG_HIGH=1, REG_LOW=2, REG_BOTH=3
  - CTRL bit positions EN_BIT=8, ONESHOT_BIT=9
  - state encodings ST_IDLE, ST_HIGH, ST_LOW
- Sub-module freqgen_chan contains one channel's shadow/active registers, FSM and tick select. It is instantiated CHANNELS times in a generate loop.
- The top level holds the prescaler, address decode and the rdata mux.

Test Plan:
1. Reset; ch0 HIGH=3, LOW=2, CTRL=0x100 -> out[0] repeats 3 clk high, 2 low (period 5). First rise is 1 cycle after the en write lands.
2. ch1 div=2, REG_BOTH=1, en -> out[1] period 8 clk, 4 high/4 low, aligned to pre_cnt[1:0]==3.
3. ch2 HIGH=4, LOW=4, CTRL=0x300 -> a single 4-cycle pulse. STATUS then reads 0, CTRL reads en=0, out[2] stays 0.
4. ch0 running 3/2; write HIGH=6 in the middle of a high phase -> the current high phase stays 3 cycles, the next high phase is 6 cycles. A write landing on the LOW-end boundary applies one period later.
5. Edge cases:
   - LOW=0, HIGH=5 -> out held 1.
   - HIGH=0 with en -> stays IDLE, out 0.
   - en=0 written during HIGH -> out 0 on the next cycle.
6. Read CTRL/HIGH/STATUS -> correct rdata one cycle after addr. Write to addr 16 with CHANNELS=4 has no effect and reads 0. rst asserted mid-period -> all out 0 and all registers read 0.
